mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the 8-bit RAM/IO port and its two clients: the instruction cache (block refills) and the load/store buffer (loads and stores).
- Accepts one request at a time, sequences the byte transfers, assembles or splits the data, and returns a one-cycle completion pulse to the requester.
- Sits directly downstream of the instruction cache's miss port and serves its 2-instruction (64-bit) refills.

Parameters:
ADDR_WIDTH, 32, address width
BLOCK_WIDTH, 1, log2 instructions per I-cache block; refill length = 4<<BLOCK_WIDTH bytes
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks an IO address

Ports:
Sys_clk  in  1  clock; all logic on rising edge
Sys_rst  in  1  synchronous active-high reset
Sys_rdy  in  1  global enable; low freezes all state
ICMC_en  in  1  I-cache refill request, held until MCIC_en
ICMC_addr  in  ADDR_WIDTH  block-aligned refill address
MCIC_en  out  1  refill done, one-cycle pulse
MCIC_block  out  32<<BLOCK_WIDTH  refill data, instruction 0 in bits [31:0]
LSBMC_en  in  1  LSB request, held until done pulse
LSBMC_wr  in  1  1 = store, 0 = load
LSBMC_len  in  2  0 = byte, 1 = half, 3 = word (bytes = len+1)
LSBMC_addr  in  ADDR_WIDTH  byte address
LSBMC_data  in  32  store data, byte 0 = [7:0]
MCLSB_r_en  out  1  load done, one-cycle pulse
MCLSB_w_en  out  1  store done, one-cycle pulse
MCLSB_data  out  32  load data, zero-extended, little-endian
mem_din  in  8  RAM read byte, valid one cycle after mem_a
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_WIDTH  RAM address
mem_wr  out  1  1 = write this cycle
io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset (sync, Sys_rst=1 at posedge): state=IDLE; mem_a=0, mem_dout=0, mem_wr=0, MCIC_en=0, MCLSB_r_en=0, MCLSB_w_en=0, MCIC_block=0, MCLSB_data=0, cnt=0. Reset mid-transfer aborts it with no done pulse.
- Sys_rdy=0: no register changes except mem_wr is forced to 0.
- States: IDLE, IC_READ, LSB_READ, LSB_WRITE.
- IDLE, edge E0:
  - LSBMC_en has priority over ICMC_en.
  - Latch addr, length n (IC: 4<<BLOCK_WIDTH; LSB: len+1) and store data; set cnt=0.
  - Read: mem_a=addr, mem_wr=0, state = IC_READ or LSB_READ.
  - Write: mem_a=addr, mem_dout=byte0, mem_wr=1, state=LSB_WRITE.
- READ:
  - At each edge E1..En the byte for address cnt is present on mem_din; capture it into byte lane cnt, cnt++, mem_a=addr+cnt+1.
  - At En the last byte is merged directly from mem_din. The done pulse (MCIC_en or MCLSB_r_en) and full data register together; state=IDLE, mem_a=0.
  - Latency: IC refill done pulse high n+... exactly 8 cycles after the accepting edge (BLOCK_WIDTH=1); word load 4 cycles; byte load 1 cycle.
- WRITE:
  - Byte i is on the bus while mem_wr=1.
  - At each edge: advance to byte i+1, or after the last byte set mem_wr=0, pulse MCLSB_w_en, state=IDLE.
  - IO stall: if addr[17:16]==IO_ADDR_HI and io_buffer_full=1, hold mem_wr=0 and do not advance. Resume byte i when the buffer is not full.
- Done pulses last exactly one cycle; data outputs hold until the next completion.
- Requester contract: en drops in the cycle its done pulse is high. The controller returns to IDLE at the done edge and may accept a new request at the following edge.
- No new request is accepted while busy; a pending en from the other client waits, so an IC request waits behind a back-to-back LSB stream only while LSB holds en.
- Address increment wraps modulo 2^ADDR_WIDTH.

Decomposition:
- Package mem_ctrl_pkg holds: state encoding, LSB length codes (LEN_B=0, LEN_H=1, LEN_W=3), IO_ADDR_HI, and refill byte count.
- Single module; no sub-module is warranted.

Test Plan:
- IC refill at 0x100, RAM bytes 0x00..0x07 -> MCIC_en pulses once 8 cycles after accept; MCIC_block = 0x07060504_03020100; mem_wr stays 0.
- LSB word load at 0x200 (bytes 0x11,0x22,0x33,0x44) -> MCLSB_r_en pulses after 4 cycles, MCLSB_data = 0x44332211; byte load of 0x203 returns 0x00000044.
- Half store 0xBEEF to 0x300 -> mem_wr=1 for two cycles with (0x300, 0xEF) then (0x301, 0xBE); MCLSB_w_en pulses once.
- ICMC_en and LSBMC_en raised together -> LSB served first, IC served right after the LSB done pulse; both return correct data.
- Byte store to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 during the stall, then one write of the byte; done pulse follows.
- Sys_rst asserted mid IC refill -> all outputs 0, no MCIC_en; Sys_rdy=0 for 2 cycles mid-load -> done is delayed by exactly 2 cycles and the data is still correct.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IC_READ   = 2'd1,
    LSB_READ  = 2'd2,
    LSB_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  localparam logic [1:0]  IO_ADDR_HI_DEF  = 2'b11;
  localparam int unsigned BLOCK_WIDTH_DEF = 1;

  // Bytes per I-cache refill for a block of 2**bw instructions.
  function automatic int unsigned refill_bytes(input int unsigned bw);
    return 32'd4 << bw;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller between the 8-bit RAM/IO port and the I-cache
// refill and load/store-buffer clients; one request in flight at a time.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BLOCK_WIDTH = BLOCK_WIDTH_DEF,
  parameter logic [1:0]  IO_ADDR_HI  = IO_ADDR_HI_DEF
) (
  input  logic                          Sys_clk,
  input  logic                          Sys_rst,
  input  logic                          Sys_rdy,
  input  logic                          ICMC_en,
  input  logic [ADDR_WIDTH-1:0]         ICMC_addr,
  output logic                          MCIC_en,
  output logic [(32<<BLOCK_WIDTH)-1:0]  MCIC_block,
  input  logic                          LSBMC_en,
  input  logic                          LSBMC_wr,
  input  logic [1:0]                    LSBMC_len,
  input  logic [ADDR_WIDTH-1:0]         LSBMC_addr,
  input  logic [31:0]                   LSBMC_data,
  output logic                          MCLSB_r_en,
  output logic                          MCLSB_w_en,
  output logic [31:0]                   MCLSB_data,
  input  logic [7:0]                    mem_din,
  output logic [7:0]                    mem_dout,
  output logic [ADDR_WIDTH-1:0]         mem_a,
  output logic                          mem_wr,
  input  logic                          io_buffer_full
);

  localparam int unsigned NBYTES = refill_bytes(BLOCK_WIDTH);
  localparam int unsigned BW     = 32 << BLOCK_WIDTH;
  localparam int unsigned IW     = $clog2(NBYTES);
  localparam int unsigned CW     = IW + 1;

  state_t                 state, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CW-1:0]          n_q, n_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [BW-1:0]          rbuf_q, rbuf_d;
  logic [ADDR_WIDTH-1:0]  mem_a_d;
  logic [7:0]             mem_dout_d;
  logic                   mem_wr_d;
  logic                   ic_done_d, rd_done_d, wr_done_d;
  logic [BW-1:0]          block_d;
  logic [31:0]            ldata_d;

  logic [BW-1:0]          merged;
  logic [IW+2:0]          bit_ofs;
  logic [CW-1:0]          next_idx;
  logic [4:0]             wr_ofs;
  logic                   last;
  logic                   io_stall;
  logic                   accept_stall;

  assign bit_ofs      = {cnt_q[IW-1:0], 3'b000};
  assign next_idx     = cnt_q + CW'(1);
  assign wr_ofs       = {next_idx[1:0], 3'b000};
  assign last         = (cnt_q == n_q - CW'(1));
  assign io_stall     = (addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign accept_stall = (LSBMC_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

  // Current mem_din dropped into lane cnt; the final byte goes straight out.
  always_comb begin
    merged = rbuf_q;
    merged[bit_ofs +: 8] = mem_din;
  end

  always_comb begin
    state_d    = state;
    addr_d     = addr_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a;
    mem_dout_d = mem_dout;
    mem_wr_d   = mem_wr;
    ic_done_d  = 1'b0;
    rd_done_d  = 1'b0;
    wr_done_d  = 1'b0;
    block_d    = MCIC_block;
    ldata_d    = MCLSB_data;

    case (state)
      IDLE: begin
        if (LSBMC_en) begin
          addr_d  = LSBMC_addr;
          n_d     = CW'(LSBMC_len) + CW'(1);
          wdata_d = LSBMC_data;
          cnt_d   = '0;
          rbuf_d  = '0;
          mem_a_d = LSBMC_addr;
          if (LSBMC_wr) begin
            mem_dout_d = LSBMC_data[7:0];
            mem_wr_d   = !accept_stall;
            state_d    = LSB_WRITE;
          end else begin
            mem_wr_d = 1'b0;
            state_d  = LSB_READ;
          end
        end else if (ICMC_en) begin
          addr_d   = ICMC_addr;
          n_d      = CW'(NBYTES);
          cnt_d    = '0;
          rbuf_d   = '0;
          mem_a_d  = ICMC_addr;
          mem_wr_d = 1'b0;
          state_d  = IC_READ;
        end
      end

      IC_READ, LSB_READ: begin
        if (last) begin
          if (state == IC_READ) begin
            ic_done_d = 1'b1;
            block_d   = merged;
          end else begin
            rd_done_d = 1'b1;
            ldata_d   = merged[31:0];
          end
          cnt_d   = '0;
          mem_a_d = '0;
          state_d = IDLE;
        end else begin
          rbuf_d  = merged;
          cnt_d   = next_idx;
          mem_a_d = addr_q + ADDR_WIDTH'(next_idx);
        end
      end

      LSB_WRITE: begin
        // A byte counts as written only after a cycle with mem_wr high;
        // stalled cycles simply re-arm the same byte.
        if (mem_wr) begin
          if (last) begin
            mem_wr_d  = 1'b0;
            wr_done_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d      = next_idx;
            mem_a_d    = addr_q + ADDR_WIDTH'(next_idx);
            mem_dout_d = wdata_q[wr_ofs +: 8];
            mem_wr_d   = !io_stall;
          end
        end else begin
          mem_wr_d = !io_stall;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      MCIC_en    <= 1'b0;
      MCLSB_r_en <= 1'b0;
      MCLSB_w_en <= 1'b0;
      MCIC_block <= '0;
      MCLSB_data <= '0;
    end else if (!Sys_rdy) begin
      mem_wr <= 1'b0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      mem_a      <= mem_a_d;
      mem_dout   <= mem_dout_d;
      mem_wr     <= mem_wr_d;
      MCIC_en    <= ic_done_d;
      MCLSB_r_en <= rd_done_d;
      MCLSB_w_en <= wr_done_d;
      MCIC_block <= block_d;
      MCLSB_data <= ldata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, corner-case
// sequences and random traffic against a byte-array reference memory.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        Sys_rst, Sys_rdy;
  logic        ICMC_en;
  logic [31:0] ICMC_addr;
  logic        MCIC_en;
  logic [63:0] MCIC_block;
  logic        LSBMC_en, LSBMC_wr;
  logic [1:0]  LSBMC_len;
  logic [31:0] LSBMC_addr, LSBMC_data;
  logic        MCLSB_r_en, MCLSB_w_en;
  logic [31:0] MCLSB_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1), .IO_ADDR_HI(2'b11)) dut (
    .Sys_clk(clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .ICMC_en(ICMC_en), .ICMC_addr(ICMC_addr),
    .MCIC_en(MCIC_en), .MCIC_block(MCIC_block),
    .LSBMC_en(LSBMC_en), .LSBMC_wr(LSBMC_wr), .LSBMC_len(LSBMC_len),
    .LSBMC_addr(LSBMC_addr), .LSBMC_data(LSBMC_data),
    .MCLSB_r_en(MCLSB_r_en), .MCLSB_w_en(MCLSB_w_en), .MCLSB_data(MCLSB_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // 4 KB RAM, aliased over the address space; read data follows mem_a.
  logic [7:0] ram     [0:4095];
  logic [7:0] ref_ram [0:4095];
  logic       preload = 1'b1;

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];

  function automatic logic [7:0] init_val(input int i);
    if (i >= 'h100 && i < 'h108) return 8'(i - 'h100);
    if (i >= 'h200 && i < 'h204) return 8'('h11 * (i - 'h1ff));
    return 8'(i * 37 + (i >> 4));
  endfunction

  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wlog.push_back('{mem_a, mem_dout});
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mdl_read(input logic [31:0] a, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_ram[12'(a + 32'(i))];
    return r;
  endfunction

  typedef struct {
    bit          ic;
    bit          wr;
    logic [1:0]  len;
    logic [31:0] a;
    logic [31:0] wd;
    logic [63:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  task automatic run_op(input bit ic, input bit wr, input logic [1:0] len,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [63:0] rd, output int lat, output bit ok);
    wlog.delete();
    rd = '0; ok = 1'b0; lat = 0;
    if (ic) begin
      ICMC_en = 1'b1; ICMC_addr = a;
    end else begin
      LSBMC_en = 1'b1; LSBMC_wr = wr; LSBMC_len = len;
      LSBMC_addr = a; LSBMC_data = wd;
    end
    tick();
    while (!ok && lat < 100) begin
      tick();
      lat++;
      if (ic ? MCIC_en : (wr ? MCLSB_w_en : MCLSB_r_en)) begin
        ok = 1'b1;
        rd = ic ? MCIC_block : {32'd0, MCLSB_data};
      end
    end
    ICMC_en = 1'b0;
    LSBMC_en = 1'b0;
  endtask

  task automatic do_and_check(input vec_t v);
    logic [63:0] rd;
    int lat, n;
    bit ok;
    n = v.ic ? 8 : int'(v.len) + 1;
    run_op(v.ic, v.wr, v.len, v.a, v.wd, rd, lat, ok);
    chk({v.nm, "_done"}, 64'(ok), 64'd1);
    chk({v.nm, "_lat"}, 64'(lat), 64'(v.lat));
    if (!v.wr) begin
      chk({v.nm, "_data"}, rd, v.exp);
      chk({v.nm, "_nowr"}, 64'(wlog.size()), 64'd0);
    end else begin
      chk({v.nm, "_wcnt"}, 64'(wlog.size()), 64'(n));
      if (wlog.size() == n) begin
        for (int i = 0; i < n; i++) begin
          chk({v.nm, "_waddr"}, 64'(wlog[i].a), 64'(v.a + 32'(i)));
          chk({v.nm, "_wbyte"}, 64'(wlog[i].d), 64'(v.wd[8*i +: 8]));
        end
      end
      for (int i = 0; i < n; i++) ref_ram[12'(v.a + 32'(i))] = v.wd[8*i +: 8];
    end
    tick();
    chk({v.nm, "_pulse1"}, {61'd0, MCIC_en, MCLSB_r_en, MCLSB_w_en}, 64'd0);
  endtask

  vec_t tbl [8];

  initial begin
    int l1, l2, pulses, n;
    vec_t v;

    for (int i = 0; i < 4096; i++) ref_ram[i] = init_val(i);
    Sys_rst = 1'b1; Sys_rdy = 1'b1; io_buffer_full = 1'b0;
    ICMC_en = 1'b0; ICMC_addr = '0;
    LSBMC_en = 1'b0; LSBMC_wr = 1'b0; LSBMC_len = '0; LSBMC_addr = '0; LSBMC_data = '0;

    tbl[0] = '{1'b1, 1'b0, LEN_B, 32'h100, 32'h0, 64'h07060504_03020100, 8, "ic_refill"};
    tbl[1] = '{1'b0, 1'b0, LEN_W, 32'h200, 32'h0, 64'h44332211, 4, "ld_word"};
    tbl[2] = '{1'b0, 1'b0, LEN_B, 32'h203, 32'h0, 64'h44, 1, "ld_byte"};
    tbl[3] = '{1'b0, 1'b1, LEN_H, 32'h300, 32'hBEEF, 64'h0, 2, "st_half"};
    tbl[4] = '{1'b0, 1'b0, LEN_H, 32'h300, 32'h0, 64'hBEEF, 2, "ld_half"};
    tbl[5] = '{1'b0, 1'b0, LEN_H, 32'h201, 32'h0, 64'h3322, 2, "ld_half_odd"};
    tbl[6] = '{1'b0, 1'b1, LEN_W, 32'h400, 32'hDEADBEEF, 64'h0, 4, "st_word"};
    tbl[7] = '{1'b0, 1'b0, LEN_W, 32'h400, 32'h0, 64'hDEADBEEF, 4, "ld_word2"};

    tick();
    preload = 1'b0;
    tick();
    chk("rst_mem_a", 64'(mem_a), 64'd0);
    chk("rst_dout", 64'(mem_dout), 64'd0);
    chk("rst_pulses", {60'd0, mem_wr, MCIC_en, MCLSB_r_en, MCLSB_w_en}, 64'd0);
    chk("rst_block", MCIC_block, 64'd0);
    chk("rst_ldata", 64'(MCLSB_data), 64'd0);
    Sys_rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) do_and_check(tbl[k]);

    // Wrap-around word load across the top of the address space.
    v = '{1'b0, 1'b0, LEN_W, 32'hFFFF_FFFE, 32'h0, 64'h0, 4, "ld_wrap"};
    v.exp = mdl_read(v.a, 4);
    do_and_check(v);

    // Simultaneous requests: LSB first, IC accepted right after its done pulse.
    ICMC_en = 1'b1; ICMC_addr = 32'h100;
    LSBMC_en = 1'b1; LSBMC_wr = 1'b0; LSBMC_len = LEN_W; LSBMC_addr = 32'h200;
    tick();
    l1 = 0;
    while (!MCLSB_r_en && l1 < 50) begin tick(); l1++; end
    LSBMC_en = 1'b0;
    chk("both_lsb_lat", 64'(l1), 64'd4);
    chk("both_lsb_data", 64'(MCLSB_data), 64'h44332211);
    chk("both_ic_wait", 64'(MCIC_en), 64'd0);
    l2 = 0;
    while (!MCIC_en && l2 < 50) begin tick(); l2++; end
    ICMC_en = 1'b0;
    chk("both_ic_lat", 64'(l2), 64'd9);
    chk("both_ic_data", MCIC_block, 64'h07060504_03020100);
    tick();

    // IO write stall: buffer full across the accept edge and two more.
    wlog.delete();
    io_buffer_full = 1'b1;
    LSBMC_en = 1'b1; LSBMC_wr = 1'b1; LSBMC_len = LEN_B;
    LSBMC_addr = 32'h0003_0000; LSBMC_data = 32'h5A;
    tick();
    chk("io_stall0", 64'(mem_wr), 64'd0);
    tick();
    chk("io_stall1", 64'(mem_wr), 64'd0);
    tick();
    chk("io_stall2", 64'(mem_wr), 64'd0);
    io_buffer_full = 1'b0;
    tick();
    chk("io_resume_wr", 64'(mem_wr), 64'd1);
    chk("io_resume_early", 64'(MCLSB_w_en), 64'd0);
    tick();
    chk("io_done", 64'(MCLSB_w_en), 64'd1);
    LSBMC_en = 1'b0;
    chk("io_wcnt", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) begin
      chk("io_waddr", 64'(wlog[0].a), 64'h0003_0000);
      chk("io_wbyte", 64'(wlog[0].d), 64'h5A);
    end
    ref_ram[0] = 8'h5A;
    tick();

    // Sys_rdy low for two edges mid word load delays done by two cycles.
    wlog.delete();
    LSBMC_en = 1'b1; LSBMC_wr = 1'b0; LSBMC_len = LEN_W; LSBMC_addr = 32'h400;
    tick();
    tick();
    l1 = 1;
    Sys_rdy = 1'b0;
    tick(); tick();
    l1 += 2;
    Sys_rdy = 1'b1;
    while (!MCLSB_r_en && l1 < 50) begin tick(); l1++; end
    LSBMC_en = 1'b0;
    chk("rdy_lat", 64'(l1), 64'd6);
    chk("rdy_data", 64'(MCLSB_data), mdl_read(32'h400, 4));
    chk("rdy_nowr", 64'(wlog.size()), 64'd0);
    tick();

    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      v.ic = (sel == 0);
      v.wr = (sel == 2);
      case ($urandom_range(0, 2))
        0:       v.len = LEN_B;
        1:       v.len = LEN_H;
        default: v.len = LEN_W;
      endcase
      v.a = $urandom;
      v.a[11:0] = 12'($urandom_range(0, 63));
      if (v.ic) v.a[2:0] = 3'b000;
      v.wd = $urandom;
      n = v.ic ? 8 : int'(v.len) + 1;
      v.exp = v.wr ? 64'd0 : mdl_read(v.a, n);
      v.lat = n;
      v.nm = $sformatf("rnd%0d", k);
      do_and_check(v);
    end

    // Reset mid refill aborts it: outputs clear and no done pulse appears.
    v = '{1'b0, 1'b0, LEN_W, 32'h200, 32'h0, 64'h44332211, 4, "pre_rst_ld"};
    do_and_check(v);
    ICMC_en = 1'b1; ICMC_addr = 32'h100;
    tick(); tick(); tick(); tick();
    Sys_rst = 1'b1;
    ICMC_en = 1'b0;
    tick();
    chk("mrst_mem_a", 64'(mem_a), 64'd0);
    chk("mrst_dout", 64'(mem_dout), 64'd0);
    chk("mrst_pulses", {60'd0, mem_wr, MCIC_en, MCLSB_r_en, MCLSB_w_en}, 64'd0);
    chk("mrst_block", MCIC_block, 64'd0);
    chk("mrst_ldata", 64'(MCLSB_data), 64'd0);
    Sys_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (MCIC_en) pulses++;
    end
    chk("mrst_no_done", 64'(pulses), 64'd0);
    v = '{1'b1, 1'b0, LEN_B, 32'h100, 32'h0, 64'h07060504_03020100, 8, "post_rst_ic"};
    do_and_check(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
